// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer in front of the single-port data memory (port 0 = load/store stage, port 1 = debug/DMA).
// Latency: grant edge -> one ACCESS cycle -> one RESP cycle (done); out-of-range requests skip ACCESS and go straight to RESP.
// Backpressure: requesters hold req until their done pulse; a losing requester simply stays pending until re-arbitrated.
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MEM_DEPTH = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          done0,
  output logic          err0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          done1,
  output logic          err1,
  output logic [DW-1:0] rdata1,
  output logic          MemRead,
  output logic          MemWrite,
  output logic [AW-1:0] address,
  output logic [DW-1:0] Write_data,
  input  logic [DW-1:0] Read_data
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  // One extra bit so the range test is exact for any AW/MEM_DEPTH pairing.
  localparam logic [AW:0] DEPTH_X = (AW+1)'(MEM_DEPTH);

  logic [1:0]    r_state;
  logic          r_last_grant;
  logic          r_sel;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_bad;
  logic [DW-1:0] r_rdata_q;

  logic          w_any_req;
  logic          w_sel;
  logic          w_win_we;
  logic [AW-1:0] w_win_addr;
  logic [DW-1:0] w_win_wdata;
  logic          w_win_bad;
  logic          w_in_access;
  logic          w_in_resp;

  // Pick the winner: a lone requester wins outright, a tie goes to the port not served last.
  always_comb begin
    w_any_req   = req0 | req1;
    w_sel       = (req0 & req1) ? ~r_last_grant : req1;
    w_win_we    = w_sel ? we1    : we0;
    w_win_addr  = w_sel ? addr1  : addr0;
    w_win_wdata = w_sel ? wdata1 : wdata0;
    w_win_bad   = ({1'b0, w_win_addr} >= DEPTH_X);
  end

  // Sequencer: latch the winner's request, run one memory cycle, then one response cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_sel        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_bad        <= 1'b0;
      r_rdata_q    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_sel        <= w_sel;
            r_last_grant <= w_sel;
            r_we         <= w_win_we;
            r_addr       <= w_win_addr;
            r_wdata      <= w_win_wdata;
            r_bad        <= w_win_bad;
            r_rdata_q    <= '0;
            r_state      <= w_win_bad ? S_RESP : S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_rdata_q <= r_we ? '0 : Read_data;
          r_state   <= S_RESP;
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Memory side is only ever non-zero during the ACCESS cycle; responses only during RESP.
  always_comb begin
    w_in_access = (r_state == S_ACCESS);
    w_in_resp   = (r_state == S_RESP);
    MemRead     = w_in_access & ~r_we;
    MemWrite    = w_in_access & r_we;
    address     = w_in_access ? r_addr : '0;
    Write_data  = (w_in_access & r_we) ? r_wdata : '0;
    done0       = w_in_resp & ~r_sel;
    done1       = w_in_resp & r_sel;
    err0        = done0 & r_bad;
    err1        = done1 & r_bad;
    rdata0      = (done0 & ~r_bad) ? r_rdata_q : '0;
    rdata1      = (done1 & ~r_bad) ? r_rdata_q : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus randomized traffic on both ports.
// Expected memory accesses and responses are queued at issue time from a reference memory.
// A negedge monitor pops and compares whenever the memory bus or a done output is active.
module tb_dmem_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          done0, err0, done1, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic          MemRead, MemWrite;
  logic [AW-1:0] address;
  logic [DW-1:0] Write_data;
  logic [DW-1:0] Read_data;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .done0(done0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .done1(done1), .err1(err1), .rdata1(rdata1),
    .MemRead(MemRead), .MemWrite(MemWrite), .address(address),
    .Write_data(Write_data), .Read_data(Read_data)
  );

  // ---------------- environment memory ----------------
  logic [31:0] env_mem [256];
  logic        init_pulse;

  function automatic logic [31:0] pat(input int i);
    return {16'hC0DE, i[7:0], ~i[7:0]};
  endfunction

  always @(posedge clk) begin
    if (init_pulse) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= pat(i);
    end else if (MemWrite) begin
      env_mem[address[7:0]] <= Write_data;
    end
  end
  assign Read_data = MemRead ? env_mem[address[7:0]] : '0;

  // ---------------- reference model and scoreboard ----------------
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wd; } acc_t;
  typedef struct { logic err; logic [31:0] rdata; } rsp_t;

  logic [31:0] ref_mem [256];
  acc_t acc_q0[$], acc_q1[$];
  rsp_t rsp_q0[$], rsp_q1[$];
  int   done_log[$];
  int   acc_cyc [2];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string nm, input int port);
    checks++;
    errors++;
    $display("FAIL %s port=%0d (cycle %0d)", nm, port, cyc);
  endtask

  // Memory semantics: a store updates the word, a load returns the latest stored word,
  // an address at or beyond DEPTH never touches memory and answers with an error.
  function automatic void expect_txn(input int p, input logic we, input logic [31:0] a,
                                     input logic [31:0] d);
    acc_t ac;
    rsp_t rs;
    if (a >= DEPTH) begin
      rs.err   = 1'b1;
      rs.rdata = '0;
    end else begin
      ac.we    = we;
      ac.addr  = a;
      ac.wd    = we ? d : 32'h0;
      rs.err   = 1'b0;
      rs.rdata = we ? 32'h0 : ref_mem[a[7:0]];
      if (we) ref_mem[a[7:0]] = d;
      if (p == 0) acc_q0.push_back(ac); else acc_q1.push_back(ac);
    end
    if (p == 0) rsp_q0.push_back(rs); else rsp_q1.push_back(rs);
  endfunction

  task automatic check_done(input int p, input logic d, input logic e, input logic [31:0] r);
    rsp_t x;
    bit   empty;
    if (d) begin
      done_log.push_back(p);
      empty = (p == 0) ? (rsp_q0.size() == 0) : (rsp_q1.size() == 0);
      if (empty) begin
        fail_now("unexpected_done", p);
      end else begin
        if (p == 0) x = rsp_q0.pop_front(); else x = rsp_q1.pop_front();
        chk(p == 0 ? "err0" : "err1", e, x.err);
        chk(p == 0 ? "rdata0" : "rdata1", r, x.rdata);
        if (!x.err) chk("done_after_access", cyc, acc_cyc[p] + 1);
      end
    end else begin
      chk(p == 0 ? "quiet_err0" : "quiet_err1", e, 0);
      chk(p == 0 ? "quiet_rdata0" : "quiet_rdata1", r, 0);
    end
  endtask

  int   mon_p;
  acc_t mon_e;

  // Monitor: every memory cycle and every done pulse is matched against the queues.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      chk("reset_ctrl", {26'h0, MemRead, MemWrite, done0, done1, err0, err1}, 0);
      chk("reset_buses", address | Write_data | rdata0 | rdata1, 0);
    end else if (reset === 1'b1) begin
      if (MemRead | MemWrite) begin
        chk("rd_wr_exclusive", MemRead & MemWrite, 0);
        mon_p = (address >= 128) ? 1 : 0;
        if ((mon_p == 0 && acc_q0.size() == 0) || (mon_p == 1 && acc_q1.size() == 0)) begin
          fail_now("unexpected_access", mon_p);
        end else begin
          if (mon_p == 0) mon_e = acc_q0.pop_front(); else mon_e = acc_q1.pop_front();
          chk("acc_we", MemWrite, mon_e.we);
          chk("acc_addr", address, mon_e.addr);
          chk("acc_wdata", Write_data, mon_e.wd);
          acc_cyc[mon_p] = cyc;
        end
      end else begin
        chk("idle_mem_bus", address | Write_data, 0);
      end
      check_done(0, done0, err0, rdata0);
      check_done(1, done1, err1, rdata1);
      chk("done_exclusive", done0 & done1, 0);
    end
  end

  // ---------------- requester ----------------
  // Called just after a rising edge; holds req until done, then drops it after the RESP edge.
  task automatic issue(input int p, input logic we, input logic [31:0] a, input logic [31:0] d,
                       output int lat);
    int start;
    bit seen;
    expect_txn(p, we, a, d);
    if (p == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    start = cyc;
    seen  = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = (p == 0) ? done0 : done1;
    end
    lat = cyc - start;
    if (!seen) fail_now("done_timeout", p);
    @(posedge clk);
    #1;
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  int lat_a, lat_b;
  bit seen_acc;
  int exp_order [4] = '{0, 1, 0, 1};

  initial begin
    reset = 1'b0; init_pulse = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b1; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_memread", MemRead, 0);
    chk("reset_memwrite", MemWrite, 0);
    chk("reset_done", {30'h0, done0, done1}, 0);
    init_pulse = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    // Contention straight out of reset: port 0 first, then strict alternation.
    done_log.delete();
    fork
      begin issue(0, 1'b0, 32'd10, 32'h0, lat_a); issue(0, 1'b0, 32'd10, 32'h0, lat_a); end
      begin issue(1, 1'b0, 32'd155, 32'h0, lat_b); issue(1, 1'b0, 32'd155, 32'h0, lat_b); end
    join
    chk("grant_count", done_log.size(), 4);
    for (int k = 0; k < 4 && k < done_log.size(); k++) chk("grant_order", done_log[k], exp_order[k]);
    repeat (2) begin @(posedge clk); #1; end

    // Store then load on port 0.
    issue(0, 1'b1, 32'd25, 32'hffff0001, lat_a);
    chk("store_latency", lat_a, 2);
    issue(0, 1'b0, 32'd25, 32'h0, lat_a);
    chk("load_latency", lat_a, 2);

    // Out-of-range store on port 1: fast error, memory untouched.
    issue(1, 1'b1, 32'd256, 32'h12345678, lat_b);
    chk("oor_latency", lat_b, 1);
    chk("oor_mem_untouched", env_mem[0], ref_mem[0]);

    // Withdraw req and scramble the address during ACCESS.
    seen_acc = 1'b0;
    fork
      issue(0, 1'b0, 32'd30, 32'h0, lat_a);
      begin
        for (int k = 0; k < 10 && !seen_acc; k++) begin
          @(negedge clk);
          if (MemRead) begin seen_acc = 1'b1; req0 = 1'b0; addr0 = 32'd99; end
        end
        if (!seen_acc) fail_now("withdraw_no_access", 0);
      end
    join
    chk("withdraw_latency", lat_a, 2);
    repeat (4) begin @(posedge clk); #1; end

    // Reset in the middle of an ACCESS cycle: the response is abandoned.
    expect_txn(0, 1'b0, 32'd50, 32'h0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd50;
    seen_acc = 1'b0;
    for (int k = 0; k < 10 && !seen_acc; k++) begin
      @(negedge clk);
      seen_acc = MemRead;
    end
    if (!seen_acc) fail_now("midreset_no_access", 0);
    #2;
    reset = 1'b0; req0 = 1'b0;
    rsp_q0.delete();
    @(negedge clk);
    chk("midreset_done0", done0, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    issue(1, 1'b0, 32'd140, 32'h0, lat_b);
    chk("post_reset_latency", lat_b, 2);

    // Randomized traffic on both ports with random gaps and occasional bad addresses.
    fork
      begin
        logic [31:0] a0;
        int lat0;
        for (int t = 0; t < 30; t++) begin
          repeat ($urandom_range(3)) begin @(posedge clk); #1; end
          if ($urandom_range(9) == 0) a0 = 32'(256 + $urandom_range(4000));
          else                        a0 = 32'($urandom_range(15));
          issue(0, 1'($urandom_range(1)), a0, $urandom(), lat0);
        end
      end
      begin
        logic [31:0] a1;
        int lat1;
        for (int t = 0; t < 30; t++) begin
          repeat ($urandom_range(3)) begin @(posedge clk); #1; end
          if ($urandom_range(9) == 0) a1 = 32'hFFFF_FF00 + 32'($urandom_range(255));
          else                        a1 = 32'(128 + $urandom_range(15));
          issue(1, 1'($urandom_range(1)), a1, $urandom(), lat1);
        end
      end
    join

    repeat (5) begin @(posedge clk); #1; end
    chk("leftover_access", acc_q0.size() + acc_q1.size(), 0);
    chk("leftover_resp", rsp_q0.size() + rsp_q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
